clock_gen: RTL and testbench
============================

// Module: clock_gen
// PURPOSE
//  Synthesizable programmable clock/pulse-train generator. It replaces the
//  behavioural `always #N clk=~clk` source used by the guide benches.
//  It divides the reference clock into a square wave clk_out, default period
//  72 reference cycles at 50 % duty. It also gives one-cycle rise/fall strobes
//  so downstream pulse generators can trigger off either edge.
//  Period and high-time are reprogrammable at run time; changes apply glitch-free.
// PARAMETERS
//  W        16  counter / period register width (bits)
//  PERIOD   72  reset-default period, reference cycles (2..2^W-1)
//  HIGH     36  reset-default high time, reference cycles (1..PERIOD-1)
// PORTS
//  clock      in   1  reference clock; all state on rising edge
//  reset      in   1  asynchronous, active-high reset
//  enable     in   1  1 = run; 0 = freeze counter and all outputs
//  load       in   1  1-cycle request to program period_in/high_in
//  period_in  in   W  new period (valid range 2..2^W-1)
//  high_in    in   W  new high time (valid range 1..period_in-1)
//  clk_out    out  1  generated square wave (registered, glitch-free)
//  rise_stb   out  1  1-cycle pulse in the cycle clk_out becomes 1
//  fall_stb   out  1  1-cycle pulse in the cycle clk_out becomes 0
//  cnt        out  W  current phase counter, 0..period-1
//  cfg_err    out  1  sticky: an invalid load was rejected
// BEHAVIOUR
//  - One clock domain (clock); reset is asynchronous, active-high.
//  - Reset sets: cnt=0, clk_out=0, rise_stb=0, fall_stb=0, cfg_err=0,
//    active period/high=PERIOD/HIGH, and clears the pending-load flag.
//  - Let low = period - high. Invariant: clk_out == (cnt >= low), registered.
//  - Each edge with enable=1: cnt <= (cnt==period-1) ? 0 : cnt+1, then
//    clk_out <= (new cnt >= low).
//  - Default waveform: after reset clk_out is low for 36 edges (cnt 0..35),
//    then high for 36 edges (cnt 36..71), then repeats. Exact period is 72.
//  - rise_stb=1 exactly in cycles where cnt==low after the edge.
//  - fall_stb=1 exactly in cycles where cnt wrapped to 0; never after reset.
//  - Strobes are registered alongside clk_out, so no extra latency.
//  - enable=0: cnt and clk_out hold; strobes forced to 0. enable returning
//    to 1 resumes from the held phase, with no skipped or repeated count.
//  - Load validation: accept if period_in>=2 and 1<=high_in<period_in.
//    On accept, store in shadow regs and set pending. Otherwise ignore the
//    load, set cfg_err (cleared only by reset), and leave the shadow untouched.
//  - Pending config is copied to the active regs on the next wrap edge
//    (cnt -> 0), then pending clears. Outputs never glitch mid-period.
//  - Load on the same edge as a wrap: the shadow is captured, and the
//    currently active period starts unchanged. The new config applies at
//    the following wrap.
//  - A second load before the wrap overwrites the shadow; last valid load wins.
//  - Reset mid-period aborts immediately; the next period starts from cnt=0
//    with the PERIOD/HIGH defaults.
//  - Widths: compare/subtract in W bits; low cannot underflow given validation.
// STRUCTURE
//  - Shared package clock_gen_pkg: W default, PERIOD/HIGH defaults, and a
//    cfg_t struct {period, high}.
//  - Natural sub-module: clock_gen_cfg holds the shadow/active registers,
//    validation and the apply-at-wrap logic. The top holds the counter and
//    output registers.
// TESTING
//  1 Reset, enable=1, defaults: clk_out 0 for 36 edges, 1 for 36 edges;
//    rise_stb at cnt=36, fall_stb at cnt=0 (t=72,144); no fall_stb after reset.
//  2 load period_in=10, high_in=3 mid-period: current 72-cycle period
//    completes, then clk_out low 7 / high 3; cfg_err stays 0.
//  3 load period_in=5, high_in=5 (invalid): cfg_err=1 sticky; waveform
//    unchanged at 72/36.
//  4 enable=0 for 20 cycles at cnt=40: cnt and clk_out hold, strobes 0;
//    after re-enable the wave resumes at 41 and the full period is 72+20.
//  5 Assert reset async at cnt=50 (clk_out=1): clk_out=0, cnt=0 immediately,
//    without waiting for a clock edge.
//  6 period_in=2, high_in=1: clk_out toggles every edge; rise_stb and
//    fall_stb alternate on successive cycles.

Source files
------------

// File: rtl/clock_gen_pkg.sv
// Shared types and defaults for the programmable clock/pulse-train generator.
// Holds the counter width, the reset-default waveform and the period/high-time record.
package clock_gen_pkg;

    localparam int unsigned W         = 16;
    localparam int unsigned DefPeriod = 72;
    localparam int unsigned DefHigh   = 36;

    typedef struct packed {
        logic [W-1:0] period;
        logic [W-1:0] high;
    } cfg_t;

    function automatic logic cfg_valid(input logic [W-1:0] period, input logic [W-1:0] high);
        return (period >= W'(2)) && (high != '0) && (high < period);
    endfunction

endpackage

// File: rtl/clock_gen_cfg.sv
// Configuration store for clock_gen: validates load requests into a shadow
// register and promotes the shadow to the active config on a counter wrap.
module clock_gen_cfg
    import clock_gen_pkg::*;
#(
    parameter int unsigned PERIOD = DefPeriod,
    parameter int unsigned HIGH   = DefHigh
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] period_in,
    input  logic [W-1:0] high_in,
    input  logic         wrap,
    output cfg_t         cfg_act,
    output cfg_t         cfg_nxt,
    output logic         cfg_err
);

    localparam cfg_t DefCfg = '{period: W'(PERIOD), high: W'(HIGH)};

    cfg_t act_q, act_d;
    cfg_t shadow_q, shadow_d;
    logic pend_q, pend_d;
    logic err_q, err_d;

    // A load on the wrap edge lands in the shadow and waits for the next wrap.
    always_comb begin
        act_d    = act_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        err_d    = err_q;
        if (wrap && pend_q) begin
            act_d = shadow_q;
        end
        if (wrap) begin
            pend_d = 1'b0;
        end
        if (load) begin
            if (cfg_valid(period_in, high_in)) begin
                shadow_d = '{period: period_in, high: high_in};
                pend_d   = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            act_q    <= DefCfg;
            shadow_q <= DefCfg;
            pend_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            act_q    <= act_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign cfg_act = act_q;
    assign cfg_nxt = act_d;
    assign cfg_err = err_q;

endmodule

// File: rtl/clock_gen.sv
// Programmable square-wave generator: phase counter plus registered clk_out
// and one-cycle rise/fall strobes, reprogrammable glitch-free at period boundaries.
module clock_gen
    import clock_gen_pkg::*;
#(
    parameter int unsigned PERIOD = DefPeriod,
    parameter int unsigned HIGH   = DefHigh
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         load,
    input  logic [W-1:0] period_in,
    input  logic [W-1:0] high_in,
    output logic         clk_out,
    output logic         rise_stb,
    output logic         fall_stb,
    output logic [W-1:0] cnt,
    output logic         cfg_err
);

    cfg_t         cfg_act;
    cfg_t         cfg_nxt;
    logic         wrap;
    logic [W-1:0] low_nxt;
    logic [W-1:0] cnt_q, cnt_d;
    logic         clk_q, clk_d;
    logic         rise_q, rise_d;
    logic         fall_q, fall_d;

    clock_gen_cfg #(
        .PERIOD (PERIOD),
        .HIGH   (HIGH)
    ) u_cfg (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .period_in (period_in),
        .high_in   (high_in),
        .wrap      (wrap),
        .cfg_act   (cfg_act),
        .cfg_nxt   (cfg_nxt),
        .cfg_err   (cfg_err)
    );

    assign wrap = enable && (cnt_q == cfg_act.period - W'(1));

    // clk_out is compared against the config that is active after this edge.
    assign low_nxt = cfg_nxt.period - cfg_nxt.high;

    always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (enable) begin
            cnt_d  = wrap ? '0 : cnt_q + W'(1);
            clk_d  = (cnt_d >= low_nxt);
            rise_d = (cnt_d == low_nxt);
            fall_d = wrap;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign cnt      = cnt_q;
    assign clk_out  = clk_q;
    assign rise_stb = rise_q;
    assign fall_stb = fall_q;

endmodule

// File: tb/tb_clock_gen.sv
// Self-checking bench for clock_gen: a table of load/run steps with
// hand-computed waveform checkpoints, plus directed enable/reset/min-period sequences.
module tb_clock_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic [15:0] period_in = '0;
    logic [15:0] high_in = '0;
    logic        clk_out, rise_stb, fall_stb, cfg_err;
    logic [15:0] cnt;

    int checks = 0;
    int errors = 0;

    clock_gen dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .load      (load),
        .period_in (period_in),
        .high_in   (high_in),
        .clk_out   (clk_out),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .cnt       (cnt),
        .cfg_err   (cfg_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit ld;
        int per;
        int hi;
        int steps;
        int cnt;
        bit clk;
        bit rise;
        bit fall;
        bit err;
    } vec_t;

    vec_t vecs[18];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int c, input bit k, input bit r, input bit f,
                           input bit e);
        chk({tag, " cnt"}, int'(cnt), c);
        chk({tag, " clk_out"}, int'(clk_out), int'(k));
        chk({tag, " rise_stb"}, int'(rise_stb), int'(r));
        chk({tag, " fall_stb"}, int'(fall_stb), int'(f));
        chk({tag, " cfg_err"}, int'(cfg_err), int'(e));
    endtask

    initial begin
        int n;
        int nrise;
        int nfall;
        bit froze;
        bit seen;

        vecs = '{
            // default 72/36 waveform from reset
            '{0, 0, 0, 1, 1, 0, 0, 0, 0},
            '{0, 0, 0, 34, 35, 0, 0, 0, 0},
            '{0, 0, 0, 1, 36, 1, 1, 0, 0},
            '{0, 0, 0, 1, 37, 1, 0, 0, 0},
            '{0, 0, 0, 34, 71, 1, 0, 0, 0},
            '{0, 0, 0, 1, 0, 0, 0, 1, 0},
            '{0, 0, 0, 36, 36, 1, 1, 0, 0},
            '{0, 0, 0, 36, 0, 0, 0, 1, 0},
            // load 10/3 mid-period: old period completes first
            '{1, 10, 3, 21, 21, 0, 0, 0, 0},
            '{0, 0, 0, 50, 71, 1, 0, 0, 0},
            '{0, 0, 0, 1, 0, 0, 0, 1, 0},
            '{0, 0, 0, 7, 7, 1, 1, 0, 0},
            '{0, 0, 0, 2, 9, 1, 0, 0, 0},
            '{0, 0, 0, 1, 0, 0, 0, 1, 0},
            // back to 72/36, then an invalid 5/5 load
            '{1, 72, 36, 1, 1, 0, 0, 0, 0},
            '{0, 0, 0, 9, 0, 0, 0, 1, 0},
            '{1, 5, 5, 36, 36, 1, 1, 0, 1},
            '{0, 0, 0, 36, 0, 0, 0, 1, 1}
        };

        // reset state, checked while reset is still held
        repeat (2) @(posedge clock);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;

        // default waveform statistics over two periods
        nrise = 0;
        nfall = 0;
        n = 0;
        for (int i = 0; i < 144; i++) begin
            step();
            nrise += int'(rise_stb);
            nfall += int'(fall_stb);
            n += int'(clk_out);
        end
        chk("default rise count", nrise, 2);
        chk("default fall count", nfall, 2);
        chk("default high cycles", n, 72);
        chk("default phase", int'(cnt), 0);

        // re-run the table from a fresh reset
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int v = 0; v < 18; v++) begin
            if (vecs[v].ld) begin
                load = 1'b1;
                period_in = 16'(vecs[v].per);
                high_in = 16'(vecs[v].hi);
            end
            step();
            load = 1'b0;
            for (int s = 1; s < vecs[v].steps; s++) step();
            chk_all($sformatf("vec%0d", v), vecs[v].cnt, vecs[v].clk, vecs[v].rise,
                    vecs[v].fall, vecs[v].err);
        end

        // enable=0 for 20 cycles at cnt=40; period stretches to 92
        n = 0;
        froze = 0;
        seen = 0;
        while (n < 200) begin
            if (!froze && cnt == 16'd40) begin
                froze = 1;
                enable = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    step();
                    n++;
                    chk("hold cnt", int'(cnt), 40);
                    chk("hold clk_out", int'(clk_out), 1);
                    chk("hold strobes", int'(rise_stb | fall_stb), 0);
                end
                enable = 1'b1;
            end
            step();
            n++;
            if (froze && !seen) begin
                seen = 1;
                chk("resume cnt", int'(cnt), 41);
            end
            if (fall_stb) break;
        end
        chk("stretched period", n, 92);

        // asynchronous reset mid-high-phase
        repeat (50) step();
        chk("pre-reset cnt", int'(cnt), 50);
        chk("pre-reset clk_out", int'(clk_out), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async reset", 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        repeat (36) step();
        chk_all("post-reset rise", 36, 1, 1, 0, 0);
        repeat (36) step();
        chk_all("post-reset fall", 0, 0, 0, 1, 0);

        // high_in=0 is rejected
        load = 1'b1;
        period_in = 16'd8;
        high_in = 16'd0;
        step();
        load = 1'b0;
        chk_all("high0 reject", 1, 0, 0, 0, 1);

        // minimum period 2/1
        load = 1'b1;
        period_in = 16'd2;
        high_in = 16'd1;
        step();
        load = 1'b0;
        n = 0;
        while (n < 200 && !fall_stb) begin
            step();
            n++;
        end
        chk("p2 wrap reached", int'(fall_stb), 1);
        for (int i = 0; i < 6; i++) begin
            step();
            if (i % 2 == 0) chk_all($sformatf("p2 edge%0d", i), 1, 1, 1, 0, 1);
            else chk_all($sformatf("p2 edge%0d", i), 0, 0, 0, 1, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
